vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_OFFSET, default 64: first VGA column of the centred 512-pixel-wide NES window.
REQ-002 Parameter RD_LAT, default 1: frame-buffer read latency in clocks, from address to vga_data; legal range 1..3.
REQ-003 clk  in  1  pixel clock, 25.175 MHz nominal; all logic on the rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 vga_data  in  8  frame-buffer pixel; format RRRGGGBB.
REQ-006 vga_row  out  10  frame-buffer read row, 0..239 inside the window, 1023 outside it.
REQ-007 vga_col  out  10  frame-buffer read column, 0..255 inside the window, 1023 outside it.
REQ-008 hsync  out  1  horizontal sync, active low.
REQ-009 vsync  out  1  vertical sync, active low.
REQ-010 red  out  4  colour channel; green  out  4; blue  out  4.
REQ-011 frame_start  out  1  one-clock pulse, asserted when counters reach h=0, v=0.
REQ-012 in_vblank  out  1  high while v_cnt >= 480.

Function
REQ-013 h_cnt SHALL count 0..799 and wrap to 0.
REQ-014 v_cnt SHALL increment when h_cnt wraps, count 0..524, and wrap to 0 when both counters wrap on the same clock.
REQ-015 Horizontal timing SHALL be: visible 0..639, front porch 640..655, sync 656..751 (low), back porch 752..799.
REQ-016 Vertical timing SHALL be: visible 0..479, front porch 480..489, sync 490..491 (low), back porch 492..524.
REQ-017 Window condition: win = (v_cnt < 480) and (H_OFFSET <= h_cnt < H_OFFSET+512).
REQ-018 When win is true, the stage-1 registers SHALL load vga_row = v_cnt>>1 and vga_col = (h_cnt-H_OFFSET)>>1; otherwise both SHALL load 1023.
- Each NES pixel is therefore doubled horizontally and vertically.
REQ-019 Address latency: vga_row/vga_col SHALL reflect the counter value of cycle t at cycle t+1.
REQ-020 Pixel output SHALL be registered at cycle t+2+RD_LAT, taking vga_data as presented at that edge.
REQ-021 Output colour mapping:
- red = {d[7:5], d[7]}
- green = {d[4:2], d[4]}
- blue = {d[1:0], d[1:0]}
REQ-022 hsync, vsync, win and active (h<640 and v<480) SHALL pass through a shift register of depth 2+RD_LAT, so sync and pixel stay aligned.
REQ-023 Outside the delayed win, red/green/blue SHALL be 0 regardless of vga_data.
- This includes the visible-but-unwindowed side borders and all blanking.
REQ-024 frame_start and in_vblank SHALL be registered from the undelayed counters (1-clock latency), for use by the PPU side.
REQ-025 Output transitions SHALL be glitch-free: every output is a flop output with no combinational path from vga_data to any port.

Reset
REQ-026 While rst_n is low, the following SHALL hold immediately (asynchronous):
- h_cnt = 0, v_cnt = 0
- vga_row = vga_col = 1023
- hsync = vsync = 1
- red = green = blue = 0
- frame_start = 0, in_vblank = 0
- all delay stages = inactive, meaning sync high, win low, active low.
REQ-027 On the first rising edge after rst_n deasserts, counting SHALL begin from h=0, v=0.
- frame_start pulses at the edge where the counters advance from (799,524) to (0,0), not at the first count after reset.
REQ-028 Reset asserted mid-line SHALL abort the frame with no partial sync pulse beyond the reset edge.

Verification
REQ-029 Reset release, then run 800*525 clocks -> exactly one hsync low run of 96 clocks per line, 525 lines per frame, vsync low for exactly 2 lines (1600 clocks), frame_start pulsing once per 420000 clocks.
REQ-030 Counters at h=64, v=0 -> vga_row=0, vga_col=0 one clock later; h=65 -> col 0; h=66 -> col 1; h=575 -> col 255; h=576 -> col 1023.
REQ-031 Model RAM returning {row[2:0], col[4:0]} with latency RD_LAT in {1,2,3} -> red/green/blue match the mapping for every window pixel, with the first window pixel appearing at output on the clock after h=63+2+RD_LAT+1, i.e. aligned to delayed win.
REQ-032 Drive vga_data=8'hFF constantly -> rgb=12'hFFF only within the 512x480 window, 0 in the side borders (columns 0..63 and 576..639) and in blanking; in_vblank high for lines 480..524.
REQ-033 Assert rst_n low at h=700, v=300 for 5 clocks -> outputs take reset values asynchronously, and the first frame_start pulse occurs exactly 420000 clocks after release.

Source files
------------

// File: rtl/vga_scanout.sv
// 640x480 VGA timing generator that scans a 256x240 frame buffer into a
// centred 512x480 window, doubling every source pixel in both directions.
module vga_scanout #(
  parameter int H_OFFSET = 64,
  parameter int RD_LAT   = 1   // frame-buffer read latency, 1..3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_data,
  output logic [9:0] vga_row,
  output logic [9:0] vga_col,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       frame_start,
  output logic       in_vblank
);

  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [9:0] H_VIS     = 10'd640;
  localparam logic [9:0] H_SYNC_LO = 10'd656;
  localparam logic [9:0] H_SYNC_HI = 10'd751;
  localparam logic [9:0] V_VIS     = 10'd480;
  localparam logic [9:0] V_SYNC_LO = 10'd490;
  localparam logic [9:0] V_SYNC_HI = 10'd491;
  localparam logic [9:0] WIN_LO    = 10'(H_OFFSET);
  localparam logic [9:0] WIN_HI    = 10'(H_OFFSET + 512);
  localparam logic [9:0] ADDR_NONE = 10'd1023;
  localparam int         DEPTH     = 2 + RD_LAT;

  logic [9:0] h_cnt_reg, h_cnt_next;
  logic [9:0] v_cnt_reg, v_cnt_next;
  logic       h_wrap, frame_wrap;
  logic       win_now, active_now, hsync_now, vsync_now;

  // Sync chains are the full pipeline depth; the window/active chains stop one
  // short because the colour register itself acts as their final stage.
  logic [DEPTH-1:0] hsync_dly_reg, vsync_dly_reg;
  logic [DEPTH-2:0] win_dly_reg, active_dly_reg;
  logic             pix_en;

  always_comb begin
    h_wrap     = (h_cnt_reg == H_LAST);
    frame_wrap = h_wrap && (v_cnt_reg == V_LAST);
    h_cnt_next = h_wrap ? 10'd0 : h_cnt_reg + 10'd1;
    v_cnt_next = v_cnt_reg;
    if (frame_wrap) begin
      v_cnt_next = 10'd0;
    end else if (h_wrap) begin
      v_cnt_next = v_cnt_reg + 10'd1;
    end
  end

  always_comb begin
    active_now = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
    win_now    = (v_cnt_reg < V_VIS) && (h_cnt_reg >= WIN_LO) && (h_cnt_reg < WIN_HI);
    hsync_now  = !((h_cnt_reg >= H_SYNC_LO) && (h_cnt_reg <= H_SYNC_HI));
    vsync_now  = !((v_cnt_reg >= V_SYNC_LO) && (v_cnt_reg <= V_SYNC_HI));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg <= 10'd0;
      v_cnt_reg <= 10'd0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // Frame-buffer address plus the PPU-side status flags, one clock behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_row     <= ADDR_NONE;
      vga_col     <= ADDR_NONE;
      frame_start <= 1'b0;
      in_vblank   <= 1'b0;
    end else begin
      if (win_now) begin
        vga_row <= v_cnt_reg >> 1;
        vga_col <= (h_cnt_reg - WIN_LO) >> 1;
      end else begin
        vga_row <= ADDR_NONE;
        vga_col <= ADDR_NONE;
      end
      frame_start <= frame_wrap;
      in_vblank   <= (v_cnt_reg >= V_VIS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_dly_reg  <= '1;
      vsync_dly_reg  <= '1;
      win_dly_reg    <= '0;
      active_dly_reg <= '0;
    end else begin
      hsync_dly_reg  <= {hsync_dly_reg[DEPTH-2:0], hsync_now};
      vsync_dly_reg  <= {vsync_dly_reg[DEPTH-2:0], vsync_now};
      win_dly_reg    <= {win_dly_reg[DEPTH-3:0], win_now};
      active_dly_reg <= {active_dly_reg[DEPTH-3:0], active_now};
    end
  end

  assign pix_en = win_dly_reg[DEPTH-2] & active_dly_reg[DEPTH-2];
  assign hsync  = hsync_dly_reg[DEPTH-1];
  assign vsync  = vsync_dly_reg[DEPTH-1];

  // RRRGGGBB expanded to 4 bits per channel by repeating the top bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end else if (pix_en) begin
      red   <= {vga_data[7:5], vga_data[7]};
      green <= {vga_data[4:2], vga_data[4]};
      blue  <= {vga_data[1:0], vga_data[1:0]};
    end else begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Randomised-frame-buffer bench for vga_scanout: a tick-based arithmetic model
// predicts every output each cycle, with literal pins at the timing boundaries.
module tb_vga_scanout;

  localparam int RD_LAT = 2;
  localparam int HOFF   = 64;
  localparam int DEPTH  = RD_LAT + 2;
  localparam logic [35:0] RESET_VEC = {10'd1023, 10'd1023, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] vga_data;
  logic [9:0] vga_row, vga_col;
  logic       hsync, vsync;
  logic [3:0] red, green, blue;
  logic       frame_start, in_vblank;

  vga_scanout #(.H_OFFSET(HOFF), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .vga_data(vga_data),
    .vga_row(vga_row), .vga_col(vga_col),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .in_vblank(in_vblank)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [240][256];
  int          hist [8];       // hist[k] = model tick k cycles ago, -1 = reset state
  logic [19:0] ahist [4];      // addresses presented by the DUT, newest first
  logic [9:0]  force_val;
  int          tick, cyc_rel, skipped, phase;
  int          n_checks = 0, n_pass = 0;
  int          hs_run = 0, vs_low_cnt = 0, fs_cnt = 0;
  bit          cmp_en = 0, cnt_en = 0, measure = 0, meas_seen = 0, forced = 0;

  function automatic int h_of(input int t); return t % 800; endfunction
  function automatic int v_of(input int t); return (t / 800) % 525; endfunction
  function automatic bit in_win(input int t);
    return (v_of(t) < 480) && (h_of(t) >= HOFF) && (h_of(t) < HOFF + 512);
  endfunction

  function automatic logic [35:0] dut_vec();
    return {vga_row, vga_col, hsync, vsync, red, green, blue, frame_start, in_vblank};
  endfunction

  function automatic logic [35:0] expected();
    int t1, td, d, r3, g3, b2;
    logic [9:0] row, col;
    logic hs, vs, fs, vb;
    logic [11:0] rgb;
    t1 = hist[1]; td = hist[DEPTH];
    row = 10'd1023; col = 10'd1023; hs = 1'b1; vs = 1'b1; rgb = 12'h0; fs = 1'b0; vb = 1'b0;
    if (t1 >= 0) begin
      if (in_win(t1)) begin
        row = 10'(v_of(t1) / 2);
        col = 10'((h_of(t1) - HOFF) / 2);
      end
      fs = (h_of(t1) == 799) && (v_of(t1) == 524);
      vb = (v_of(t1) >= 480);
    end
    if (td >= 0) begin
      hs = !((h_of(td) >= 656) && (h_of(td) <= 751));
      vs = !((v_of(td) >= 490) && (v_of(td) <= 491));
      if (in_win(td)) begin
        d  = int'(mem[v_of(td) / 2][(h_of(td) - HOFF) / 2]);
        r3 = d / 32; g3 = (d / 4) % 8; b2 = d % 4;
        rgb = 12'((r3 * 2 + r3 / 4) * 256 + (g3 * 2 + g3 / 4) * 16 + b2 * 5);
      end
    end
    return {row, col, hs, vs, rgb, fs, vb};
  endfunction

  function automatic logic [7:0] ram_read(input logic [19:0] a);
    int r, c;
    r = int'(a[19:10]); c = int'(a[9:0]);
    if (r < 240 && c < 256) return mem[r][c];
    return 8'hFF;
  endfunction

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (forced) begin
      release dut.v_cnt_reg;
      forced = 0;
    end
    if (rst_n) begin
      tick++; cyc_rel++;
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = tick;
    end
    for (int k = 3; k > 0; k--) ahist[k] = ahist[k-1];
    ahist[0] = {vga_row, vga_col};
    vga_data = ram_read(ahist[RD_LAT]);
  endtask

  // Skip the counters forward within the current frame (h must not be 799).
  task automatic jump(input int target);
    skipped += (target - v_of(tick)) * 800;
    tick = target * 800 + h_of(tick);
    hist[0] = tick;
    force_val = 10'(target);
    force dut.v_cnt_reg = force_val;
    forced = 1;
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    tick = 0;
    hist[0] = 0;
    for (int k = 1; k < 8; k++) hist[k] = -1;
  endtask

  task automatic pins();
    int h, v;
    h = h_of(tick); v = v_of(tick);
    if (phase == 1) begin
      if (tick == 1)           chk("no_fs_first_edge", 36'(frame_start), 36'd0);
      if (tick == 65)          chk("addr_h64", 36'({vga_row, vga_col}), 36'({10'd0, 10'd0}));
      if (tick == 66)          chk("col_h65", 36'(vga_col), 36'd0);
      if (tick == 67)          chk("col_h66", 36'(vga_col), 36'd1);
      if (tick == 576)         chk("col_h575", 36'(vga_col), 36'd255);
      if (tick == 577)         chk("col_h576", 36'({vga_row, vga_col}), 36'({10'd1023, 10'd1023}));
      if (tick == 63 + DEPTH)  chk("rgb_before_win", 36'({red, green, blue}), 36'h000);
      if (tick == 64 + DEPTH)  chk("rgb_first_win", 36'({red, green, blue}), 36'hFFF);
      if (tick == 576 + DEPTH) chk("rgb_right_border", 36'({red, green, blue}), 36'h000);
      if (tick == 655 + DEPTH) chk("hsync_h655", 36'(hsync), 36'd1);
      if (tick == 656 + DEPTH) chk("hsync_h656", 36'(hsync), 36'd0);
      if (tick == 751 + DEPTH) chk("hsync_h751", 36'(hsync), 36'd0);
      if (tick == 752 + DEPTH) chk("hsync_h752", 36'(hsync), 36'd1);
    end else if (phase == 2) begin
      if (v == 479 && h == 10)    chk("vblank_v479", 36'(in_vblank), 36'd0);
      if (v == 480 && h == 10)    chk("vblank_v480", 36'(in_vblank), 36'd1);
      if (v == 489 && h == 700)   chk("vsync_v489", 36'(vsync), 36'd1);
      if (v == 490 && h == DEPTH) chk("vsync_v490", 36'(vsync), 36'd0);
      if (v == 492 && h == DEPTH) chk("vsync_v492", 36'(vsync), 36'd1);
      if (v == 0 && h == 0)       chk("fs_at_wrap", 36'(frame_start), 36'd1);
      if (v == 0 && h == 1)       chk("fs_one_clock", 36'(frame_start), 36'd0);
    end
  endtask

  // Per-cycle compare against the model, plus run-length bookkeeping.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk($sformatf("out_v%0d_h%0d", v_of(tick), h_of(tick)), dut_vec(), expected());
        if (!rst_n) hs_run = 0;
        else if (!hsync) hs_run++;
        else if (hs_run > 0) begin
          chk("hsync_run", 36'(hs_run), 36'd96);
          hs_run = 0;
        end
        if (cnt_en) begin
          if (!vsync) vs_low_cnt++;
          if (frame_start) fs_cnt++;
        end
        if (measure && frame_start) begin
          chk("fs_after_release", 36'(cyc_rel + skipped), 36'd420000);
          measure = 0;
          meas_seen = 1;
        end
      end
    end
  end

  initial begin
    bit done;
    int n3;
    for (int r = 0; r < 240; r++)
      for (int c = 0; c < 256; c++)
        mem[r][c] = 8'($urandom);
    mem[0][0] = 8'hFF;
    vga_data = 8'hFF;
    for (int k = 0; k < 4; k++) ahist[k] = 20'hFFFFF;
    force_val = 10'd0;
    skipped = 0; cyc_rel = 0; phase = 0;
    rst_n = 1'b1;
    #1;
    enter_reset();
    cmp_en = 1;
    #1;
    chk("reset_async", dut_vec(), RESET_VEC);
    repeat (3) step();
    chk("reset_hold", dut_vec(), RESET_VEC);
    #2 rst_n = 1'b1;
    cyc_rel = 0; skipped = 0; phase = 1;

    n3 = 3 * 800 + 100 + $urandom_range(0, 400);
    while (tick < n3) begin
      step();
      pins();
    end

    // Vertical blanking and frame wrap.
    phase = 2;
    jump(478);
    cnt_en = 1; vs_low_cnt = 0; fs_cnt = 0;
    done = 0;
    for (int i = 0; i < 45000 && !done; i++) begin
      step();
      pins();
      if (v_of(tick) == 2 && fs_cnt > 0) done = 1;
    end
    cnt_en = 0;
    chk("reach_next_frame", 36'(done), 36'd1);
    chk("fs_per_frame", 36'(fs_cnt), 36'd1);
    chk("vsync_low_clocks", 36'(vs_low_cnt), 36'd1600);

    // Mid-line reset at h=700, v=300.
    phase = 3;
    jump(300);
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step();
      if (h_of(tick) == 700 && v_of(tick) == 300) done = 1;
    end
    chk("reach_h700_v300", 36'(done), 36'd1);
    #2 enter_reset();
    #1 chk("reset_midline", dut_vec(), RESET_VEC);
    repeat (5) step();
    chk("reset_midline_held", dut_vec(), RESET_VEC);
    #2 rst_n = 1'b1;
    cyc_rel = 0; skipped = 0; phase = 1;
    while (tick < 1600) begin
      step();
      pins();
    end

    // First frame_start after the release must land 420000 clocks later.
    phase = 3;
    jump(524);
    measure = 1; meas_seen = 0;
    for (int i = 0; i < 2000 && !meas_seen; i++) step();
    chk("fs_seen_after_release", 36'(meas_seen), 36'd1);
    measure = 0;
    repeat (900) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
